// File: rtl/display_cmd_dispatcher_pkg.sv
// Shared command-word layout, action codes and dispatcher state constants
// for the display command path.
package display_cmd_pkg;

  localparam int CMD_W = 32;

  localparam int COMP_MSB   = 31;
  localparam int COMP_LSB   = 26;
  localparam int SUB_MSB    = 25;
  localparam int SUB_LSB    = 21;
  localparam int ACTION_MSB = 20;
  localparam int ACTION_LSB = 17;
  localparam int TYPE_MSB   = 16;
  localparam int TYPE_LSB   = 14;
  localparam int BUF_BIT    = 13;
  localparam int MSG_MSB    = 12;
  localparam int MSG_LSB    = 0;

  localparam logic [3:0] ACTION_NOP   = 4'b0000;
  localparam logic [3:0] ACTION_WRITE = 4'b0001;
  localparam logic [3:0] ACTION_FLUSH = 4'b1111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE        = 2'd0;
  localparam state_t ST_ISSUE       = 2'd1;
  localparam state_t ST_WAIT_VBLANK = 2'd2;

  function automatic logic [3:0] cmd_action(input logic [CMD_W-1:0] word);
    return word[ACTION_MSB:ACTION_LSB];
  endfunction

  // Every issued word targets the buffer that is not on screen.
  function automatic logic [CMD_W-1:0] stamp_back(input logic [CMD_W-1:0] word,
                                                  input logic front);
    logic [CMD_W-1:0] stamped;
    stamped          = word;
    stamped[BUF_BIT] = ~front;
    return stamped;
  endfunction

endpackage

// File: rtl/display_cmd_dispatcher_fifo.sv
// First-word-fall-through command FIFO: head is valid whenever empty is low,
// level counts 0..DEPTH exactly using one extra pointer bit.
module cmd_fifo
  import display_cmd_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = CMD_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push is still taken when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

endmodule

// File: rtl/display_cmd_dispatcher.sv
// Avalon-MM command buffer for the display components: issues one word per
// cycle stamped with the back-buffer bit and holds frame commits until vblank.
module display_cmd_dispatcher
  import display_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        front_buf
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          ctrl_wr;
  logic          vblank;
  logic          overflow;
  logic          pending_flush;
  logic [31:0]   head;
  logic [LW-1:0] level;
  logic [15:0]   frame_count;
  state_t        state;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writedata),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign push          = chipselect && write && !address;
  assign ctrl_wr       = chipselect && write && address;
  assign vblank        = (vcount == 10'(VBLANK_LINE)) && (hcount == '0);
  assign pending_flush = (state == ST_WAIT_VBLANK);

  always_comb begin
    // NOTE: assign a default before any branch so no path infers a latch.
    pop = 1'b0;
    if (!empty) begin
      if (state == ST_WAIT_VBLANK) pop = vblank;
      else                         pop = (cmd_action(head) != ACTION_FLUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_out     <= '0;
      front_buf   <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
      readdata    <= '0;
    end else begin
      cmd_out <= '0;
      case (state)
        ST_WAIT_VBLANK: begin
          if (pop) begin
            cmd_out     <= stamp_back(head, front_buf);
            front_buf   <= ~front_buf;
            frame_count <= frame_count + 16'd1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          // A non-empty FIFO that is not popped has a commit at its head.
          if (pop) begin
            cmd_out <= stamp_back(head, front_buf);
            state   <= ST_ISSUE;
          end else if (!empty) begin
            state <= ST_WAIT_VBLANK;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase

      if (push && full && !pop)           overflow <= 1'b1;
      else if (ctrl_wr && writedata[0])   overflow <= 1'b0;

      if (chipselect && read) begin
        readdata <= {frame_count, 6'b0, overflow, pending_flush, front_buf,
                     2'b0, 5'(level)};
      end
    end
  end

endmodule

// File: tb/tb_display_cmd_dispatcher.sv
// Bench for display_cmd_dispatcher: directed frame/commit scenarios plus
// random Avalon traffic, compared every cycle against a queue-based model.
module tb_display_cmd_dispatcher;

  localparam int         DEPTH   = 16;
  localparam int         VBL     = 480;
  localparam int         H_TOTAL = 4;
  localparam int         V_TOTAL = 490;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        chipselect = 1'b0;
  logic        write      = 1'b0;
  logic        read       = 1'b0;
  logic        address    = 1'b0;
  logic [31:0] writedata  = '0;
  logic [9:0]  hcount     = '0;
  logic [9:0]  vcount     = '0;
  logic [31:0] readdata;
  logic [31:0] cmd_out;
  logic        front_buf;

  int n_checks = 0;
  int n_pass   = 0;
  int h = 0;
  int v = 0;

  // Reference model: queued words, whether a head commit has been seen,
  // displayed buffer, frame counter, sticky overflow.
  logic [31:0] q[$];
  bit          armed;
  bit          m_fb;
  logic [15:0] m_fc;
  bit          m_ovf;
  logic [31:0] exp_cmd;
  logic [31:0] exp_rd;

  display_cmd_dispatcher #(.FIFO_DEPTH(DEPTH), .VBLANK_LINE(VBL)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .hcount     (hcount),
    .vcount     (vcount),
    .cmd_out    (cmd_out),
    .front_buf  (front_buf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit rst, input bit cs, input bit wr, input bit rd,
                            input bit ad, input logic [31:0] wd);
    logic [31:0] w;
    bit          vb;
    if (rst) begin
      q.delete();
      armed = 0; m_fb = 0; m_fc = '0; m_ovf = 0; exp_cmd = '0;
      return;
    end
    vb = (v == VBL) && (h == 0);
    if (cs && rd) exp_rd = {m_fc, 6'b0, m_ovf, armed, m_fb, 2'b0, 5'(q.size())};
    exp_cmd = '0;
    if (q.size() > 0) begin
      w     = q[0];
      w[13] = ~m_fb;
      if (q[0][20:17] == 4'hF) begin
        if (armed && vb) begin
          exp_cmd = w;
          void'(q.pop_front());
          m_fb  = ~m_fb;
          m_fc  = m_fc + 16'd1;
          armed = 0;
        end else begin
          armed = 1;
        end
      end else begin
        exp_cmd = w;
        void'(q.pop_front());
      end
    end
    if (cs && wr && !ad) begin
      if (q.size() < DEPTH) q.push_back(wd);
      else m_ovf = 1;
    end
    if (cs && wr && ad && wd[0]) m_ovf = 0;
  endtask

  task automatic step(input bit rst, input bit cs, input bit wr, input bit rd,
                      input bit ad, input logic [31:0] wd);
    reset = rst; chipselect = cs; write = wr; read = rd; address = ad; writedata = wd;
    hcount = 10'(h); vcount = 10'(v);
    @(posedge clk);
    model_edge(rst, cs, wr, rd, ad, wd);
    #1;
    check("cmd_out", cmd_out, exp_cmd);
    check("front_buf", 32'(front_buf), 32'(m_fb));
    if (cs && rd && !rst) check("readdata", readdata, exp_rd);
    h++;
    if (h == H_TOTAL) begin
      h = 0;
      v = (v + 1) % V_TOTAL;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, '0);
  endtask

  task automatic push(input logic [31:0] w);
    step(0, 1, 1, 0, 0, w);
  endtask

  task automatic ctrl(input logic [31:0] w);
    step(0, 1, 1, 0, 1, w);
  endtask

  task automatic status();
    step(0, 1, 0, 1, 1, '0);
  endtask

  task automatic wait_line(input int line);
    for (int i = 0; i <= H_TOTAL * V_TOTAL && !(v == line && h == 0); i++) idle(1);
  endtask

  initial begin
    int          r;
    logic [31:0] w;
    @(negedge clk);
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    check("rst_cmd", cmd_out, 32'h0);
    status();
    check("rst_status", readdata, 32'h0);

    push(32'h3C02_4000);
    idle(1);
    check("ground_cmd", cmd_out, 32'h3C02_6000);
    idle(1);
    check("ground_idle", cmd_out, 32'h0);

    wait_line(100);
    push(32'h001E_0000);
    wait_line(VBL);
    idle(1);
    check("flush1_cmd", cmd_out, 32'h001E_2000);
    check("flush1_fb", 32'(front_buf), 32'd1);
    status();
    check("flush1_frames", 32'(readdata[31:16]), 32'd1);

    wait_line(100);
    push(32'h001E_0000);
    wait_line(VBL);
    idle(1);
    check("flush2_cmd", cmd_out, 32'h001E_0000);
    check("flush2_fb", 32'(front_buf), 32'd0);
    status();
    check("flush2_frames", 32'(readdata[31:16]), 32'd2);

    wait_line(10);
    push(32'h001E_0000);
    for (int i = 0; i < 17; i++) push(32'h3C02_4000 | 32'(i));
    status();
    check("ovf_level", 32'(readdata[4:0]), 32'd16);
    check("ovf_flag", 32'(readdata[9]), 32'd1);
    check("ovf_pending", 32'(readdata[8]), 32'd1);
    ctrl(32'h1);
    status();
    check("ovf_clear", 32'(readdata[9]), 32'd0);
    wait_line(VBL);
    idle(24);

    wait_line(10);
    push(32'h0002_0001);
    push(32'h0002_0002);
    push(32'h0002_0003);
    push(32'h001E_0000);
    push(32'h0002_0004);
    idle(4);
    wait_line(VBL);
    idle(1);
    check("order_flush", cmd_out, 32'h001E_0000);
    idle(1);
    check("order_tail", cmd_out, 32'h0002_2004);

    wait_line(10);
    push(32'h001E_0000);
    idle(5);
    step(1, 0, 0, 0, 0, '0);
    check("wrst_cmd", cmd_out, 32'h0);
    check("wrst_fb", 32'(front_buf), 32'd0);
    status();
    check("wrst_status", readdata, 32'h0);
    wait_line(VBL);
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 2) begin
        step(1, 0, 0, 0, 0, '0);
      end else begin
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 25) begin
          w[20:17] = ($urandom_range(0, 99) == 0) ? 4'hF : 4'($urandom_range(0, 14));
          push(w);
        end else if (r < 30) begin
          ctrl(w);
        end else if (r < 40) begin
          status();
        end else begin
          idle(1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
